store_coalesce_unit: RTL and testbench

STORE_COALESCE_UNIT -- requirements
Module: store_coalesce_unit

---
 rtl/store_coalesce_unit.sv | 76 +++++++
 tb/tb_store_coalesce_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/store_coalesce_unit.sv
// store_coalesce_unit: merges stores to the same doubleword into one D$ write
module store_coalesce_unit #(
  parameter int PLEN    = 56,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 8
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_req_i,
  output logic              in_gnt_o,
  input  logic [PLEN-1:0]   in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [7:0]        in_be_i,
  output logic              out_req_o,
  input  logic              out_gnt_i,
  output logic [PLEN-1:0]   out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [7:0]        out_be_o,
  input  logic              drain_i,
  output logic              empty_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_e;
  state_e            state_q, state_d;
  logic [PLEN-4:0]   addr_q, addr_d, in_word;
  logic [DATA_W-1:0] data_q, data_d, be_mask, merged_data;
  logic [7:0]        be_q, be_d, merged_be;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              same_word, load, merge, granted, hold_exit, unused_ok;
  genvar i;
  for (i = 0; i < DATA_W / 8; i++) begin : g_mask
    assign be_mask[i*8 +: 8] = {8{in_be_i[i]}};
  end
  assign in_word     = in_addr_i[PLEN-1:3];
  assign same_word   = in_word == addr_q;
  assign merged_data = (data_q & ~be_mask) | (in_data_i & be_mask);
  assign merged_be   = be_q | in_be_i;
  assign unused_ok   = ^{in_addr_i[2:0], page_offset_i[2:0]};
  assign out_addr_o  = {addr_q, 3'b000};
  assign out_data_o  = data_q;
  assign out_be_o    = be_q;
  // next-state, entry update and handshake outputs
  always_comb begin
    granted   = state_q == ISSUE && out_gnt_i;
    load      = in_req_i && (state_q == IDLE || granted);
    merge     = in_req_i && state_q == HOLD && same_word;
    hold_exit = in_req_i ? (!same_word || &merged_be || drain_i) : (drain_i || cnt_q == CW'(TIMEOUT - 1));
    addr_d    = load ? in_word : addr_q;
    data_d    = load ? in_data_i : merge ? merged_data : data_q;
    be_d      = load ? in_be_i : merge ? merged_be : granted ? 8'h00 : be_q;
    cnt_d     = (load || merge) ? '0 : state_q == HOLD ? cnt_q + 1'b1 : cnt_q;
    state_d   = load ? (&in_be_i ? ISSUE : HOLD) : granted ? IDLE : (state_q == HOLD && hold_exit) ? ISSUE : state_q;
    in_gnt_o  = !rst_i && (state_q == IDLE || merge || granted);
    out_req_o = !rst_i && state_q == ISSUE;
    empty_o   = rst_i || (state_q == IDLE && !in_req_i);
    page_offset_matches_o = !rst_i && ((state_q != IDLE && page_offset_i[11:3] == addr_q[8:0]) || (in_req_i && page_offset_i[11:3] == in_addr_i[11:3]));
  end
  // state and entry registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_store_coalesce_unit.sv
// tb_store_coalesce_unit: directed checks of merge, timeout, backpressure, drain, hazard and reset
module tb_store_coalesce_unit;
  logic        clk = 1'b0, rst, in_req, in_gnt, out_req, out_gnt, drain, empty, match;
  logic [55:0] in_addr, out_addr;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_be, out_be;
  logic [11:0] page_off;
  int checks = 0, errors = 0;
  store_coalesce_unit #(.PLEN(56), .DATA_W(64), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .in_req_i(in_req), .in_gnt_o(in_gnt), .in_addr_i(in_addr),
    .in_data_i(in_data), .in_be_i(in_be), .out_req_o(out_req), .out_gnt_i(out_gnt),
    .out_addr_o(out_addr), .out_data_o(out_data), .out_be_o(out_be), .drain_i(drain),
    .empty_o(empty), .page_offset_i(page_off), .page_offset_matches_o(match)
  );
  always #5 clk = ~clk;
  task automatic quiet();
    in_req = 0; in_addr = '0; in_data = '0; in_be = '0; out_gnt = 0; drain = 0; page_off = '0;
  endtask
  task automatic store(input logic [55:0] a, input logic [7:0] be, input logic [63:0] d);
    in_req = 1; in_addr = a; in_be = be; in_data = d;
  endtask
  task automatic test_reset();
    @(negedge clk); rst = 1; quiet(); store(56'h1000, 8'h0F, 64'h1); out_gnt = 1; #1;
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL rst_out_req: got %b expected 0", out_req); end
    checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL rst_in_gnt: got %b expected 0", in_gnt); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL rst_match: got %b expected 0", match); end
    @(negedge clk); @(negedge clk); rst = 0; quiet(); #1;
    checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL post_rst_in_gnt: got %b expected 1", in_gnt); end
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL post_rst_out_req: got %b expected 0", out_req); end
  endtask
  task automatic test_merge();
    @(negedge clk); store(56'h1000, 8'h0F, 64'h0000_0000_1122_3344); #1;
    checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL merge_gnt1: got %b expected 1", in_gnt); end
    @(negedge clk); store(56'h1004, 8'hF0, 64'hAABB_CCDD_0000_0000); #1;
    checks++; if (in_gnt !== 1'b1 || out_req !== 1'b0) begin errors++; $display("FAIL merge_gnt2: got gnt=%b req=%b expected gnt=1 req=0", in_gnt, out_req); end
    @(negedge clk); quiet(); out_gnt = 1; #1;
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL merge_req: got %b expected 1", out_req); end
    checks++; if (out_addr !== 56'h1000) begin errors++; $display("FAIL merge_addr: got %h expected 1000", out_addr); end
    checks++; if (out_be !== 8'hFF) begin errors++; $display("FAIL merge_be: got %h expected ff", out_be); end
    checks++; if (out_data !== 64'hAABB_CCDD_1122_3344) begin errors++; $display("FAIL merge_data: got %h expected aabbccdd11223344", out_data); end
    @(negedge clk); quiet(); #1;
    checks++; if (empty !== 1'b1 || out_req !== 1'b0) begin errors++; $display("FAIL merge_done: got empty=%b req=%b expected empty=1 req=0", empty, out_req); end
  endtask
  task automatic test_timeout();
    @(negedge clk); store(56'h2002, 8'h04, 64'h0000_0000_00AA_0000);
    @(negedge clk); quiet(); #1;
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL timeout_c0: got %b expected 0", out_req); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      checks++; if (out_req !== (k == 8)) begin errors++; $display("FAIL timeout_c%0d: got %b expected %b", k, out_req, k == 8); end
    end
    checks++; if (out_addr !== 56'h2000 || out_be !== 8'h04 || out_data !== 64'hAA_0000) begin errors++; $display("FAIL timeout_entry: got addr=%h be=%h data=%h expected 2000 04 aa0000", out_addr, out_be, out_data); end
    out_gnt = 1;
    @(negedge clk); quiet(); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL timeout_empty: got %b expected 1", empty); end
  endtask
  task automatic test_mismatch();
    @(negedge clk); store(56'h3000, 8'h01, 64'h55);
    @(negedge clk); store(56'h3008, 8'h02, 64'h6600); #1;
    checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL mm_hold_gnt: got %b expected 0", in_gnt); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (in_gnt !== 1'b0 || out_req !== 1'b1) begin errors++; $display("FAIL mm_bp%0d: got gnt=%b req=%b expected gnt=0 req=1", k, in_gnt, out_req); end
      checks++; if (out_addr !== 56'h3000 || out_be !== 8'h01 || out_data !== 64'h55) begin errors++; $display("FAIL mm_stable%0d: got %h %h %h expected 3000 01 55", k, out_addr, out_be, out_data); end
    end
    @(negedge clk); out_gnt = 1; #1;
    checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL mm_grant_gnt: got %b expected 1", in_gnt); end
    @(negedge clk); quiet(); drain = 1; #1;
    checks++; if (out_req !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL mm_second_hold: got req=%b empty=%b expected 0 0", out_req, empty); end
    @(negedge clk); quiet(); out_gnt = 1; #1;
    checks++; if (out_req !== 1'b1 || out_addr !== 56'h3008 || out_be !== 8'h02 || out_data !== 64'h6600) begin errors++; $display("FAIL mm_second_issue: got req=%b %h %h %h expected 1 3008 02 6600", out_req, out_addr, out_be, out_data); end
    @(negedge clk); quiet(); #1;
  endtask
  task automatic test_drain();
    @(negedge clk); store(56'h4000, 8'h01, 64'h77);
    @(negedge clk); quiet(); drain = 1; #1;
    checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL drain_pre: got %b expected 0", out_req); end
    @(negedge clk); quiet(); #1;
    checks++; if (out_req !== 1'b1 || out_addr !== 56'h4000 || out_be !== 8'h01) begin errors++; $display("FAIL drain_issue: got req=%b %h %h expected 1 4000 01", out_req, out_addr, out_be); end
    drain = 1; out_gnt = 1;
    @(negedge clk); quiet(); #1;
    checks++; if (empty !== 1'b1 || out_req !== 1'b0) begin errors++; $display("FAIL drain_empty: got empty=%b req=%b expected 1 0", empty, out_req); end
    store(56'h4000, 8'h01, 64'h77);
    @(negedge clk); store(56'h4001, 8'h02, 64'h8800); drain = 1; #1;
    checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL drain_merge_gnt: got %b expected 1", in_gnt); end
    @(negedge clk); quiet(); out_gnt = 1; #1;
    checks++; if (out_req !== 1'b1 || out_be !== 8'h03 || out_data !== 64'h8877) begin errors++; $display("FAIL drain_merge: got req=%b be=%h data=%h expected 1 03 8877", out_req, out_be, out_data); end
    @(negedge clk); quiet(); #1;
  endtask
  task automatic test_hazard();
    @(negedge clk); store(56'h5010, 8'h01, 64'h1);
    @(negedge clk); quiet(); page_off = 12'h014; #1;
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL hz_hit: got %b expected 1", match); end
    page_off = 12'h018; #1;
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL hz_miss: got %b expected 0", match); end
    drain = 1;
    @(negedge clk); quiet(); out_gnt = 1;
    @(negedge clk); quiet(); page_off = 12'h014; #1;
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL hz_idle: got %b expected 0", match); end
    store(56'h6010, 8'h01, 64'h1); #1;
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL hz_incoming: got %b expected 1", match); end
    in_req = 0;
  endtask
  task automatic test_back_to_back();
    @(negedge clk); store(56'h7000, 8'h0F, 64'h4433_2211);
    @(negedge clk); store(56'h7008, 8'hFF, 64'h0123_4567_89AB_CDEF);
    @(negedge clk); out_gnt = 1; #1;
    checks++; if (out_addr !== 56'h7000 || out_be !== 8'h0F || in_gnt !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h %h gnt=%b expected 7000 0f 1", out_addr, out_be, in_gnt); end
    @(negedge clk); quiet(); out_gnt = 1; #1;
    checks++; if (out_req !== 1'b1 || out_addr !== 56'h7008 || out_be !== 8'hFF || out_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL b2b_second: got req=%b %h %h %h expected 1 7008 ff 0123456789abcdef", out_req, out_addr, out_be, out_data); end
    @(negedge clk); quiet(); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
  endtask
  task automatic test_reset_mid_issue();
    @(negedge clk); store(56'h8000, 8'hFF, 64'h9);
    @(negedge clk); quiet(); #1;
    checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL rmi_issue: got %b expected 1", out_req); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if (out_req !== 1'b0 || empty !== 1'b1 || in_gnt !== 1'b0) begin errors++; $display("FAIL rmi_reset: got req=%b empty=%b gnt=%b expected 0 1 0", out_req, empty, in_gnt); end
    rst = 0; #1;
    checks++; if (out_req !== 1'b0 || in_gnt !== 1'b1) begin errors++; $display("FAIL rmi_after: got req=%b gnt=%b expected 0 1", out_req, in_gnt); end
  endtask
  initial begin
    rst = 1; quiet();
    test_reset();
    test_merge();
    test_timeout();
    test_mismatch();
    test_drain();
    test_hazard();
    test_back_to_back();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
